// File: rtl/input_pkg.sv
// Shared constants and helpers for the board-input labs: clock rate,
// default debounce interval and the widths of the DE-series board I/O.
package input_pkg;

    localparam int CLK_HZ              = 50_000_000;
    localparam int DEBOUNCE_MS_DEFAULT = 10;

    localparam int KEY_WIDTH     = 4;
    localparam int SW_WIDTH      = 10;
    localparam int LEDR_WIDTH    = 10;
    localparam int HEX_DIGITS    = 6;
    localparam int HEX_SEG_WIDTH = 7;

    // Cycles of CLK_HZ that make up the given number of milliseconds.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    // Counter width able to hold values 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: two-flop synchronizer, stability counter,
// debounced level and registered one-cycle press/release pulses.
module debounce_bit
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released,
    output logic press_d
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          act;
    logic          flip;
    logic          release_d;

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        act       = s2 ^ ACTIVE_LOW;
        flip      = (act != level) && (cnt == CNT_LAST);
        press_d   = flip & act;
        release_d = flip & ~act;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1       <= ACTIVE_LOW;
            s2       <= ACTIVE_LOW;
            cnt      <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            pressed  <= press_d;
            released <= release_d;
            if (act == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= act;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions WIDTH raw KEY/SW inputs into debounced active-high levels
// with per-bit press/release pulses and a combined registered press flag.
module input_conditioner
    import input_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS_DEFAULT),
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] press_out,
    output logic [WIDTH-1:0] release_out,
    output logic             any_press_out
);

    logic [WIDTH-1:0] press_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (raw_in[i]),
            .level   (level_out[i]),
            .pressed (press_out[i]),
            .released(release_out[i]),
            .press_d (press_d[i])
        );
    end

    // Built from the pre-register press terms so it lines up with press_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_press_out <= 1'b0;
        end else begin
            any_press_out <= |press_d;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: an active-low 4-cycle instance and
// an active-high 1-cycle instance share the clock and reset.
module tb_input_conditioner;

    logic       clk;
    logic       reset_n;
    logic [3:0] raw_a;
    logic [3:0] raw_b;
    logic [3:0] level_a, press_a, release_a;
    logic [3:0] level_b, press_b, release_b;
    logic       any_a, any_b;

    int total  = 0;
    int passed = 0;

    input_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_in       (raw_a),
        .level_out    (level_a),
        .press_out    (press_a),
        .release_out  (release_a),
        .any_press_out(any_a)
    );

    input_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_in       (raw_b),
        .level_out    (level_b),
        .press_out    (press_b),
        .release_out  (release_b),
        .any_press_out(any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then park on the falling edge for sampling and driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        raw_a   = 4'b0000;
        raw_b   = 4'b0000;
        tick();
        tick();
        total++;
        if ({level_a, press_a, release_a, any_a} !== 13'd0)
            $display("[TB] FAIL reset_a: got lvl=%b prs=%b rel=%b any=%b, want all 0", level_a, press_a, release_a, any_a);
        else passed++;
        total++;
        if ({level_b, press_b, release_b, any_b} !== 13'd0)
            $display("[TB] FAIL reset_b: got lvl=%b prs=%b rel=%b any=%b, want all 0", level_b, press_b, release_b, any_b);
        else passed++;
        raw_a   = 4'b1111;
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({level_a, press_a, release_a, any_a, level_b, press_b, release_b, any_b} !== 26'd0)
                $display("[TB] FAIL post_reset_idle cyc%0d: got a=%b/%b/%b/%b b=%b/%b/%b/%b, want all 0",
                         i, level_a, press_a, release_a, any_a, level_b, press_b, release_b, any_b);
            else passed++;
        end
    endtask

    task automatic test_clean_press();
        raw_a = 4'b1110;
        for (int e = 0; e < 5; e++) tick();
        total++;
        if (level_a !== 4'b0000 || press_a !== 4'b0000)
            $display("[TB] FAIL press_early: got lvl=%b prs=%b, want 0000/0000", level_a, press_a);
        else passed++;
        tick();
        total++;
        if (level_a !== 4'b0001 || press_a !== 4'b0001 || release_a !== 4'b0000 || any_a !== 1'b1)
            $display("[TB] FAIL press_edge5: got lvl=%b prs=%b rel=%b any=%b, want 0001/0001/0000/1",
                     level_a, press_a, release_a, any_a);
        else passed++;
        tick();
        total++;
        if (level_a !== 4'b0001 || press_a !== 4'b0000 || any_a !== 1'b0)
            $display("[TB] FAIL press_one_cycle: got lvl=%b prs=%b any=%b, want 0001/0000/0", level_a, press_a, any_a);
        else passed++;
    endtask

    task automatic test_release();
        raw_a = 4'b1111;
        for (int e = 0; e < 5; e++) begin
            tick();
            total++;
            if (level_a !== 4'b0001 || press_a !== 4'b0000 || release_a !== 4'b0000)
                $display("[TB] FAIL release_hold edge%0d: got lvl=%b prs=%b rel=%b, want 0001/0000/0000",
                         e, level_a, press_a, release_a);
            else passed++;
        end
        tick();
        total++;
        if (level_a !== 4'b0000 || release_a !== 4'b0001 || press_a !== 4'b0000 || any_a !== 1'b0)
            $display("[TB] FAIL release_edge5: got lvl=%b rel=%b prs=%b any=%b, want 0000/0001/0000/0",
                     level_a, release_a, press_a, any_a);
        else passed++;
        tick();
        total++;
        if (release_a !== 4'b0000)
            $display("[TB] FAIL release_one_cycle: got rel=%b, want 0000", release_a);
        else passed++;
    endtask

    task automatic test_glitch();
        raw_a = 4'b1101;
        for (int e = 0; e < 3; e++) tick();
        raw_a = 4'b1111;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (level_a !== 4'b0000 || press_a !== 4'b0000 || release_a !== 4'b0000)
                $display("[TB] FAIL glitch3 cyc%0d: got lvl=%b prs=%b rel=%b, want 0000/0000/0000",
                         e, level_a, press_a, release_a);
            else passed++;
        end
        // A four-cycle low is just long enough to register as a press.
        raw_a = 4'b1101;
        for (int e = 0; e < 4; e++) tick();
        raw_a = 4'b1111;
        tick();
        total++;
        if (level_a !== 4'b0000)
            $display("[TB] FAIL glitch4_edge4: got lvl=%b, want 0000", level_a);
        else passed++;
        tick();
        total++;
        if (level_a !== 4'b0010 || press_a !== 4'b0010 || any_a !== 1'b1)
            $display("[TB] FAIL glitch4_edge5: got lvl=%b prs=%b any=%b, want 0010/0010/1", level_a, press_a, any_a);
        else passed++;
        for (int e = 6; e < 9; e++) tick();
        total++;
        if (level_a !== 4'b0010 || release_a !== 4'b0000)
            $display("[TB] FAIL glitch4_hold: got lvl=%b rel=%b, want 0010/0000", level_a, release_a);
        else passed++;
        tick();
        total++;
        if (level_a !== 4'b0000 || release_a !== 4'b0010 || press_a !== 4'b0000)
            $display("[TB] FAIL glitch4_release: got lvl=%b rel=%b prs=%b, want 0000/0010/0000", level_a, release_a, press_a);
        else passed++;
        tick();
    endtask

    task automatic test_simultaneous();
        raw_a = 4'b0000;
        for (int e = 0; e < 5; e++) tick();
        total++;
        if (level_a !== 4'b0000)
            $display("[TB] FAIL simul_early: got lvl=%b, want 0000", level_a);
        else passed++;
        tick();
        total++;
        if (level_a !== 4'b1111 || press_a !== 4'b1111 || any_a !== 1'b1 || release_a !== 4'b0000)
            $display("[TB] FAIL simul_press: got lvl=%b prs=%b rel=%b any=%b, want 1111/1111/0000/1",
                     level_a, press_a, release_a, any_a);
        else passed++;
        tick();
        total++;
        if (press_a !== 4'b0000 || any_a !== 1'b0)
            $display("[TB] FAIL simul_one_cycle: got prs=%b any=%b, want 0000/0", press_a, any_a);
        else passed++;
    endtask

    task automatic test_reset_mid();
        raw_a = 4'b1111;
        // Edges 0..3 leave each counter at 2, partway to the release.
        for (int e = 0; e < 4; e++) tick();
        reset_n = 1'b0;
        #1;
        total++;
        if ({level_a, press_a, release_a, any_a} !== 13'd0)
            $display("[TB] FAIL reset_async: got lvl=%b prs=%b rel=%b any=%b, want all 0", level_a, press_a, release_a, any_a);
        else passed++;
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({level_a, press_a, release_a, any_a} !== 13'd0)
                $display("[TB] FAIL reset_mid_idle cyc%0d: got lvl=%b prs=%b rel=%b any=%b, want all 0",
                         i, level_a, press_a, release_a, any_a);
            else passed++;
        end
    endtask

    task automatic test_active_high();
        raw_b = 4'b0100;
        tick();
        tick();
        total++;
        if (level_b !== 4'b0000)
            $display("[TB] FAIL ah_edge1: got lvl=%b, want 0000", level_b);
        else passed++;
        tick();
        total++;
        if (level_b !== 4'b0100 || press_b !== 4'b0100 || any_b !== 1'b1)
            $display("[TB] FAIL ah_edge2: got lvl=%b prs=%b any=%b, want 0100/0100/1", level_b, press_b, any_b);
        else passed++;
        tick();
        total++;
        if (level_b !== 4'b0100 || press_b !== 4'b0000)
            $display("[TB] FAIL ah_one_cycle: got lvl=%b prs=%b, want 0100/0000", level_b, press_b);
        else passed++;
        raw_b = 4'b0000;
        tick();
        tick();
        tick();
        total++;
        if (level_b !== 4'b0000 || release_b !== 4'b0100 || press_b !== 4'b0000)
            $display("[TB] FAIL ah_release: got lvl=%b rel=%b prs=%b, want 0000/0100/0000", level_b, release_b, press_b);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_active_high();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Input-side counterpart to the board-output logic that drives LEDR and HEX.
- Conditions raw board inputs (KEY pushbuttons or SW slide switches) before any sequential logic uses them.
- Per bit: 2-flop synchronizer, counter-based debounce filter, and one-cycle press/release pulses.
- Sits between the top-level KEY/SW pins and every downstream FSM or counter.

Parameters:
- WIDTH, 4, number of independent input bits conditioned.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the level changes (10 ms at 50 MHz). Legal range is 1 or more.
- ACTIVE_LOW, 1, when 1 the raw inputs are active-low (KEY) and are inverted internally. When 0 they are active-high (SW).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset. Assertion is asynchronous. Release is assumed synchronous to clk at the top level.
- raw_in  input  WIDTH  unsynchronized board inputs.
- level_out  output  WIDTH  debounced level, active-high regardless of ACTIVE_LOW.
- press_out  output  WIDTH  one-cycle pulse when level_out[i] goes 0->1.
- release_out  output  WIDTH  one-cycle pulse when level_out[i] goes 1->0.
- any_press_out  output  1  OR-reduction of press_out, registered in the same cycle.

Behaviour:
- The interface is one clock, clk. Reset is asynchronous and active-low on reset_n. While reset_n=0:
  - level_out, press_out, release_out, any_press_out = 0.
  - All counters = 0.
  - Synchronizer flops hold the inactive raw level: 1 if ACTIVE_LOW=1, else 0.
- Reset mid-debounce discards the partial count. No pulse is generated by reset assertion or release.
- Polarity: act[i] = raw_in[i] XOR ACTIVE_LOW, applied after the synchronizer.
- Synchronizer: two flops per bit (s1, s2). s2 is the only value the filter sees.
- Filter, per bit and independent:
  - cnt width is $clog2(DEBOUNCE_CYCLES+1).
  - If act(s2) == level_out[i]: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level_out[i] <= act(s2) and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: raw_in changes before edge n and is held. s2 updates at edge n+1. level_out changes at edge n+1+DEBOUNCE_CYCLES.
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES cycles returns cnt to 0. level_out is unchanged and no pulse is generated.
- Pulses:
  - press_out[i] and release_out[i] are registered and asserted for exactly the one cycle beginning at the edge where level_out[i] flips.
  - Otherwise they are 0. They are never asserted simultaneously for the same bit.
- Simultaneous events: bits are fully independent, so several bits may pulse in the same cycle. any_press_out is 1 if any press_out bit is 1.
- DEBOUNCE_CYCLES=1: level_out follows s2 one cycle later. No filtering beyond synchronization.
- Counter never wraps: it clears on level change or on agreement, so it stays at or below DEBOUNCE_CYCLES-1.

Decomposition:
- Package input_pkg holds:
  - CLK_HZ = 50_000_000.
  - DEBOUNCE_MS_DEFAULT = 10.
  - A function computing cycles from milliseconds.
  - localparam widths shared with later labs.
- One sub-module, debounce_bit, implements a single bit (synchronizer, counter, level, pulses) with parameters DEBOUNCE_CYCLES and ACTIVE_LOW.
- input_conditioner instantiates WIDTH copies of debounce_bit in a generate loop and ORs the press pulses into a registered any_press_out.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1 unless noted):
- Reset: hold reset_n=0 with raw_in=4'b0000 -> all outputs 0. Release reset with raw_in=4'b1111 held 20 cycles -> outputs stay 0, no pulses.
- Clean press: raw_in[0] 1->0 before edge 0 and held -> level_out[0]=1 after edge 5. press_out[0]=1 for exactly the cycle after edge 5. any_press_out=1 in that same cycle.
- Glitch: raw_in[1]=0 for 3 cycles, then back to 1 -> level_out[1] stays 0, no pulses. Repeat with 4 cycles -> level_out[1]=1 after edge 5.
- Release: after the clean press, raw_in[0] 0->1 held -> level_out[0]=0 five edges later, release_out[0] pulses once, press_out stays 0.
- Simultaneous/reset mid-op: raw_in 1111->0000 at once -> press_out=4'b1111 in the same cycle. Pull reset_n low at cnt=2 during a second transition -> all outputs 0 immediately (asynchronous), no pulse after release.
- ACTIVE_LOW=0, DEBOUNCE_CYCLES=1: raw_in[2] 0->1 -> level_out[2]=1 after edge 2, press_out[2] pulses one cycle.
